// File: rtl/input_memory_node_pkg.sv
// input_memory_node_pkg: OBI types, FSM encoding and sizing helpers for input_memory_node
//   obi_req_t / obi_resp_t : OBI master request / response bundles
//   imn_state_e            : S_IDLE=00, S_MREQ=01, S_DRAIN=10, S_DONE=11
//   imn_fifo_ptr_w(depth)  : pointer/usage width, $clog2(depth)+1
//   imn_words(size)        : ceil(size/4) as a 15-bit word count
package input_memory_node_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_MREQ  = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } imn_state_e;
  localparam int unsigned IMN_WORD_BYTES = 4;
  function automatic int unsigned imn_fifo_ptr_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction
  // 0xFFFF rounds up to 16384, which still fits in 15 bits
  function automatic logic [14:0] imn_words(logic [15:0] size);
    return 15'((17'(size) + 17'd3) >> 2);
  endfunction
endpackage

// File: rtl/input_memory_node_fifo.sv
// imn_fifo: synchronous-reset data FIFO for input_memory_node
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   push_i, data_i  : write strobe and data (accepted when not full, or when full with a pop)
//   pop_i           : read strobe (ignored when empty)
//   data_o          : head entry, valid while !empty_o
//   full_o, empty_o : status flags
//   usage_o         : number of stored entries
module imn_fifo import input_memory_node_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = imn_fifo_ptr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [31:0]   data_i,
  input  logic          pop_i,
  output logic [31:0]   data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW-1:0] usage_o
);
  localparam int unsigned AW = PW - 1;
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          do_push, do_pop;
  assign usage_o = wptr_q - rptr_q;
  assign full_o  = usage_o == PW'(DEPTH);
  assign empty_o = usage_o == '0;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rptr_q[AW-1:0]];
  always_comb begin
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/input_memory_node.sv
// input_memory_node: streams a contiguous block of words from memory over OBI into the fabric
//   clk_i, rst_ni             : clock, synchronous active-low reset
//   execute_i / done_o        : start (sampled in S_IDLE) / sticky completion
//   input_addr_i, input_size_i: base byte address and block size in bytes
//   input_stride_i            : byte stride, present only with INPUT_MEMORY_NODE_STRIDE_EN
//   masters_req_o/resp_i      : OBI read master
//   dout_o, dout_v_o, dout_r_i: FIFO head to the fabric with valid/ready
// Optional feature macro: INPUT_MEMORY_NODE_STRIDE_EN (address increment = stride instead of 4)
module input_memory_node import input_memory_node_pkg::*; #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        execute_i,
  output logic        done_o,
  input  logic [31:0] input_addr_i,
  input  logic [15:0] input_size_i,
`ifdef INPUT_MEMORY_NODE_STRIDE_EN
  input  logic [15:0] input_stride_i,
`endif
  output obi_req_t    masters_req_o,
  input  obi_resp_t   masters_resp_i,
  output logic [31:0] dout_o,
  output logic        dout_v_o,
  input  logic        dout_r_i
);
  localparam int unsigned IMN_FIFO_PTR_W = imn_fifo_ptr_w(FIFO_DEPTH);
  localparam int unsigned CW = IMN_FIFO_PTR_W + 1;
  imn_state_e                state_q, state_d;
  logic [31:0]               base_q, base_d, offset_q, offset_d, inc;
  logic [14:0]               words_q, words_d, issued_q, issued_d, received_q, received_d;
  logic [IMN_FIFO_PTR_W-1:0] outst_q, outst_d, fifo_usage;
  logic [CW-1:0]             credit;
  logic                      fifo_empty, fifo_full, req, gnt, rv_ok, push, pop;
`ifdef INPUT_MEMORY_NODE_STRIDE_EN
  logic [15:0]               stride_q, stride_d;
  assign inc = {16'b0, stride_q};
`else
  assign inc = 32'(IMN_WORD_BYTES);
`endif
  // Credit = buffered + in-flight words; only pops lower it, so a raised req holds until gnt
  assign credit = {1'b0, fifo_usage} + {1'b0, outst_q};
  assign req    = (state_q == S_MREQ) && (issued_q < words_q)
                  && (outst_q < IMN_FIFO_PTR_W'(MAX_OUTSTANDING)) && (credit < CW'(FIFO_DEPTH));
  assign gnt    = req & masters_resp_i.gnt;
  // Responses outside an active transfer (e.g. after a mid-run reset) are dropped
  assign rv_ok  = masters_resp_i.rvalid & ((state_q == S_MREQ) | (state_q == S_DRAIN));
  assign pop    = dout_v_o & dout_r_i;
  assign push   = rv_ok & (~fifo_full | pop);
  assign done_o   = state_q == S_DONE;
  assign dout_v_o = ~fifo_empty;
  assign masters_req_o = '{req: req, we: 1'b0, be: 4'b1111, addr: base_q + offset_q, wdata: 32'h0};
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    words_d    = words_q;
    issued_d   = issued_q + 15'(gnt);
    received_d = received_q + 15'(push);
    offset_d   = gnt ? offset_q + inc : offset_q;
    outst_d    = outst_q + IMN_FIFO_PTR_W'(gnt) - IMN_FIFO_PTR_W'(push);
`ifdef INPUT_MEMORY_NODE_STRIDE_EN
    stride_d   = stride_q;
`endif
    case (state_q)
      S_IDLE: if (execute_i) begin
        state_d    = (input_size_i == 16'd0) ? S_DONE : S_MREQ;
        base_d     = input_addr_i;
        words_d    = imn_words(input_size_i);
        issued_d   = '0;
        received_d = '0;
        offset_d   = '0;
        outst_d    = '0;
`ifdef INPUT_MEMORY_NODE_STRIDE_EN
        stride_d   = input_stride_i;
`endif
      end
      S_MREQ:  if (gnt && issued_d == words_q) state_d = S_DRAIN;
      S_DRAIN: if (received_q == words_q && fifo_empty) state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      words_q    <= '0;
      issued_q   <= '0;
      received_q <= '0;
      offset_q   <= '0;
      outst_q    <= '0;
`ifdef INPUT_MEMORY_NODE_STRIDE_EN
      stride_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      words_q    <= words_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      offset_q   <= offset_d;
      outst_q    <= outst_d;
`ifdef INPUT_MEMORY_NODE_STRIDE_EN
      stride_q   <= stride_d;
`endif
    end
  end
  imn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (masters_resp_i.rdata),
    .pop_i   (pop),
    .data_o  (dout_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );
endmodule

// File: tb/tb_input_memory_node.sv
// tb_input_memory_node: randomized bench for input_memory_node with a transaction-level reference model
module tb_input_memory_node;
  import input_memory_node_pkg::*;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  logic        clk_i = 0, rst_ni = 0, execute_i = 0, dout_r_i = 0;
  logic        done_o, dout_v_o;
  logic [31:0] input_addr_i = 0, dout_o;
  logic [15:0] input_size_i = 0, stride_v = 16'd4;
  obi_req_t    masters_req_o;
  obi_resp_t   masters_resp_i = '0;
  input_memory_node #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .execute_i      (execute_i),
    .done_o         (done_o),
    .input_addr_i   (input_addr_i),
    .input_size_i   (input_size_i),
`ifdef INPUT_MEMORY_NODE_STRIDE_EN
    .input_stride_i (stride_v),
`endif
    .masters_req_o  (masters_req_o),
    .masters_resp_i (masters_resp_i),
    .dout_o         (dout_o),
    .dout_v_o       (dout_v_o),
    .dout_r_i       (dout_r_i)
  );
  always #5 clk_i = ~clk_i;
  int n_vec = 0, n_err = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mem(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction
  function automatic logic [31:0] at(logic [31:0] q[$], int i);
    return (i < q.size()) ? q[i] : 32'hxxxxxxxx;
  endfunction
  // environment knobs
  int gnt_mode = 0, lat_lo = 1, lat_hi = 1, rdy_pct = 100, cyc = 0, last_due = 0;
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t rq[$];
  // reference model: transfer-level bookkeeping
  bit          m_ok = 0, m_run = 0, m_done = 0, req_seen = 0, p_req = 0, p_gnt = 0;
  int          m_words = 0, m_iss = 0, m_rcv = 0, m_out = 0, max_out = 0;
  logic [31:0] m_base = 0, m_inc = 4, p_addr = 0;
  logic [31:0] m_q[$], alog[$], plog[$];
  initial forever begin
    bit er;
    logic [31:0] ea;
    @(negedge clk_i);
    cyc++;
    er = m_ok && m_run && m_iss < m_words && m_out < MAXO && (m_q.size() + m_out) < DEPTH;
    ea = m_base + m_inc * m_iss;
    if (m_ok) begin
      chk("done_o", done_o, m_done);
      chk("req", masters_req_o.req, er);
      chk("req_const", {masters_req_o.we, masters_req_o.be, masters_req_o.wdata}, {1'b0, 4'hF, 32'h0});
      if (er) chk("addr", masters_req_o.addr, ea);
      chk("dout_v_o", dout_v_o, m_q.size() != 0);
      if (m_q.size() != 0) chk("dout_o", dout_o, m_q[0]);
      if (p_req && !p_gnt) begin
        chk("req_hold", masters_req_o.req, 1);
        chk("addr_hold", masters_req_o.addr, p_addr);
      end
    end
    if (masters_req_o.req === 1'b1) req_seen = 1;
    masters_resp_i.gnt = gnt_mode != 0 ? ($urandom_range(1) == 1) : 1'b1;
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      masters_resp_i.rvalid = 1;
      masters_resp_i.rdata  = rq[0].data;
      void'(rq.pop_front());
    end else begin
      masters_resp_i.rvalid = 0;
      masters_resp_i.rdata  = $urandom;
    end
    if (masters_req_o.req === 1'b1 && masters_resp_i.gnt) begin
      int d;
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      rq.push_back('{d, mem(masters_req_o.addr)});
    end
    dout_r_i = int'($urandom_range(99)) < rdy_pct;
    p_req  = m_ok && rst_ni && masters_req_o.req === 1'b1;
    p_gnt  = masters_resp_i.gnt;
    p_addr = masters_req_o.addr;
    if (!rst_ni) begin
      m_ok = 1; m_run = 0; m_done = 0; m_iss = 0; m_rcv = 0; m_out = 0;
      m_q.delete();
    end else if (m_ok) begin
      if (!m_run && !m_done) begin
        if (execute_i) begin
          if (input_size_i == 0) m_done = 1;
          else begin
            m_run = 1; m_base = input_addr_i; m_words = (int'(input_size_i) + 3) / 4;
            m_iss = 0; m_rcv = 0; m_out = 0;
`ifdef INPUT_MEMORY_NODE_STRIDE_EN
            m_inc = {16'b0, stride_v};
`else
            m_inc = 32'd4;
`endif
          end
        end
      end else if (m_run) begin
        if (m_rcv == m_words && m_q.size() == 0) begin
          m_run = 0; m_done = 1;
        end
        if (m_q.size() != 0 && dout_r_i) plog.push_back(m_q.pop_front());
        if (masters_resp_i.rvalid) begin
          chk("push_not_full", dut.u_fifo.full_o, 0);
          m_q.push_back(mem(m_base + m_inc * m_rcv));
          m_rcv++; m_out--;
        end
        if (er && masters_resp_i.gnt) begin
          alog.push_back(ea);
          m_iss++; m_out++;
          if (m_out > max_out) max_out = m_out;
        end
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset();
    rst_ni = 0;
    tick(1);
    rst_ni = 1;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && rq.size() != 0; i++) tick(1);
  endtask
  task automatic start(logic [31:0] a, logic [15:0] s, logic [15:0] st);
    alog.delete(); plog.delete(); req_seen = 0; max_out = 0;
    input_addr_i = a; input_size_i = s; stride_v = st; execute_i = 1;
    tick(1);
    execute_i = 0; input_addr_i = $urandom; input_size_i = 16'($urandom); stride_v = 16'($urandom);
  endtask
  task automatic wait_done(int lim);
    for (int i = 0; i < lim && done_o !== 1'b1; i++) tick(1);
    n_vec++;
    if (done_o !== 1'b1) begin
      n_err++;
      $display("FAIL wait_done: done_o %b after %0d cycles, expected 1", done_o, lim);
    end
  endtask
  initial begin
    tick(3);
    rst_ni = 1;
    chk("rst_done", done_o, 0);
    chk("rst_req", masters_req_o.req, 0);
    chk("rst_dout_v", dout_v_o, 0);
    // size 0 finishes at once and execute is then ignored
    start(32'h40, 16'd0, 16'd4);
    chk("size0_done", done_o, 1);
    execute_i = 1; input_size_i = 16'd16;
    tick(6);
    execute_i = 0;
    chk("size0_req_seen", req_seen, 0);
    chk("size0_dout_v", dout_v_o, 0);
    chk("size0_done_sticky", done_o, 1);
    // basic stream
    do_reset();
    start(32'h1000, 16'd16, 16'd4);
    wait_done(200);
    chk("basic_grants", alog.size(), 4);
    chk("basic_pops", plog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_addr", at(alog, i), 32'h1000 + 32'(4 * i));
      chk("basic_data", at(plog, i), mem(32'h1000 + 32'(4 * i)));
    end
    chk("basic_data0_literal", at(plog, 0), 32'h2DC1D3C3);
    // unaligned size with random grant/ready
    do_reset();
    gnt_mode = 1; rdy_pct = 60;
    start(32'h1000, 16'd13, 16'd4);
    wait_done(300);
    chk("unaligned_pops", plog.size(), 4);
    chk("unaligned_addr3", at(alog, 3), 32'h100C);
    // backpressure
    do_reset();
    rdy_pct = 0;
    start(32'h8000, 16'd64, 16'd4);
    tick(50);
    chk("bp_grants", alog.size(), DEPTH);
    chk("bp_dout_v", dout_v_o, 1);
    chk("bp_no_pops", plog.size(), 0);
    rdy_pct = 100;
    wait_done(600);
    chk("bp_pops", plog.size(), 16);
    for (int i = 0; i < 16; i++) chk("bp_data", at(plog, i), mem(32'h8000 + 32'(4 * i)));
    // outstanding limit with slow responses
    do_reset();
    gnt_mode = 0; lat_lo = 10; lat_hi = 10; rdy_pct = 70;
    start(32'h100, 16'd32, 16'd4);
    wait_done(1000);
    chk("os_max", max_out, MAXO);
    chk("os_pops", plog.size(), 8);
    // reset in the middle with responses still pending
    do_reset();
    lat_lo = 6; lat_hi = 6; rdy_pct = 100;
    start(32'h5000, 16'd32, 16'd4);
    for (int i = 0; i < 50 && alog.size() < 2; i++) tick(1);
    chk("mid_grants", alog.size() >= 2, 1);
    do_reset();
    chk("mid_done", done_o, 0);
    chk("mid_req", masters_req_o.req, 0);
    for (int i = 0; i < 10; i++) begin
      chk("mid_dout_v", dout_v_o, 0);
      tick(1);
    end
    drain();
    lat_lo = 1; lat_hi = 1;
    start(32'h3000, 16'd8, 16'd4);
    wait_done(200);
    chk("restart_addr0", at(alog, 0), 32'h3000);
    chk("restart_addr1", at(alog, 1), 32'h3004);
    chk("restart_pops", plog.size(), 2);
    // address wrap
    do_reset();
    start(32'hFFFF_FFF8, 16'd16, 16'd4);
    wait_done(200);
    chk("wrap_addr2", at(alog, 2), 32'h0);
    chk("wrap_data3", at(plog, 3), mem(32'h4));
`ifdef INPUT_MEMORY_NODE_STRIDE_EN
    do_reset();
    start(32'h2000, 16'd12, 16'd8);
    wait_done(200);
    chk("stride_addr0", at(alog, 0), 32'h2000);
    chk("stride_addr1", at(alog, 1), 32'h2008);
    chk("stride_addr2", at(alog, 2), 32'h2010);
    chk("stride_pops", plog.size(), 3);
    do_reset();
    start(32'h2000, 16'd8, 16'd0);
    wait_done(200);
    chk("stride0_addr1", at(alog, 1), 32'h2000);
`endif
    // random transfers
    for (int k = 0; k < 12; k++) begin
      int sz;
      do_reset();
      drain();
      gnt_mode = int'($urandom_range(1));
      lat_lo = 1; lat_hi = int'($urandom_range(6, 1));
      rdy_pct = int'($urandom_range(100, 20));
      sz = int'($urandom_range(100));
      start($urandom, 16'(sz), 16'($urandom_range(64)));
      wait_done(sz * 40 + 200);
      chk("rand_pops", plog.size(), (sz + 3) / 4);
    end
    // largest block: 0xFFFF bytes rounds up to 16384 words
    do_reset();
    drain();
    gnt_mode = 0; lat_lo = 1; lat_hi = 1; rdy_pct = 100;
    start(32'h0, 16'hFFFF, 16'd4);
    wait_done(20000);
    chk("max_pops", plog.size(), 16384);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
